// File: rtl/mips_lsu_pkg.sv
// Shared encodings and decode helpers for the MIPS load/store unit.
// Byte lanes are big-endian: byte offset 0 maps to bits 31:24.
package mips_lsu_pkg;

    typedef enum logic [3:0] {
        OP_LB  = 4'd0,
        OP_LBU = 4'd1,
        OP_LH  = 4'd2,
        OP_LHU = 4'd3,
        OP_LW  = 4'd4,
        OP_SB  = 4'd5,
        OP_SH  = 4'd6,
        OP_SW  = 4'd7,
        OP_LL  = 4'd8,
        OP_SC  = 4'd9
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ISSUE,
        S_RESP
    } state_e;

    typedef enum logic [1:0] {
        SZ_BYTE,
        SZ_HALF,
        SZ_WORD
    } size_e;

    localparam logic [3:0] LANE_B0  = 4'b1000;
    localparam logic [3:0] LANE_HI  = 4'b1100;
    localparam logic [3:0] LANE_LO  = 4'b0011;
    localparam logic [3:0] LANE_ALL = 4'b1111;

    function automatic logic is_legal(logic [3:0] op);
        return op <= OP_SC;
    endfunction

    function automatic logic is_load(logic [3:0] op);
        return op inside {OP_LB, OP_LBU, OP_LH, OP_LHU, OP_LW, OP_LL};
    endfunction

    function automatic logic is_store(logic [3:0] op);
        return op inside {OP_SB, OP_SH, OP_SW};
    endfunction

    function automatic size_e op_size(logic [3:0] op);
        case (op)
            OP_LB, OP_LBU, OP_SB: return SZ_BYTE;
            OP_LH, OP_LHU, OP_SH: return SZ_HALF;
            default:              return SZ_WORD;
        endcase
    endfunction

    function automatic logic is_aligned(logic [3:0] op, logic [1:0] off);
        case (op_size(op))
            SZ_BYTE: return 1'b1;
            SZ_HALF: return !off[0];
            default: return off == 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/mips_lsu_if.sv
// Pipeline, memory and reservation-control signals of the load/store unit.
interface mips_lsu_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic [3:0]        req_op;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [4:0]        req_rd;

    logic              rsp_valid;
    logic [31:0]       rsp_data;
    logic [4:0]        rsp_rd;
    logic              rsp_we;
    logic              rsp_err;

    logic              mem_req;
    logic [3:0]        mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              mem_ack;
    logic [31:0]       mem_rdata;

    logic              snoop_we;
    logic [ADDR_W-1:0] snoop_addr;
    logic              resv_clr;

    modport slave (
        input  req_valid, req_op, req_addr, req_wdata, req_rd,
        input  mem_ack, mem_rdata, snoop_we, snoop_addr, resv_clr,
        output req_ready, rsp_valid, rsp_data, rsp_rd, rsp_we, rsp_err,
        output mem_req, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output req_valid, req_op, req_addr, req_wdata, req_rd,
        output mem_ack, mem_rdata, snoop_we, snoop_addr, resv_clr,
        input  req_ready, rsp_valid, rsp_data, rsp_rd, rsp_we, rsp_err,
        input  mem_req, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mips_lsu_lane.sv
// Combinational lane logic: store strobes/replication and load extraction/extension.
module mips_lsu_lane
    import mips_lsu_pkg::*;
(
    input  logic [3:0]  st_op_i,
    input  logic [1:0]  st_off_i,
    input  logic [31:0] st_data_i,
    output logic [3:0]  st_strb_o,
    output logic [31:0] st_data_o,
    input  logic [3:0]  ld_op_i,
    input  logic [1:0]  ld_off_i,
    input  logic [31:0] ld_rdata_i,
    output logic [31:0] ld_data_o
);
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic        ld_sext;

    always_comb begin
        st_strb_o = LANE_ALL;
        st_data_o = st_data_i;
        case (op_size(st_op_i))
            SZ_BYTE: begin
                st_strb_o = LANE_B0 >> st_off_i;
                st_data_o = {4{st_data_i[7:0]}};
            end
            SZ_HALF: begin
                st_strb_o = st_off_i[1] ? LANE_LO : LANE_HI;
                st_data_o = {2{st_data_i[15:0]}};
            end
            default: ;
        endcase
    end

    always_comb begin
        case (ld_off_i)
            2'd0:    ld_byte = ld_rdata_i[31:24];
            2'd1:    ld_byte = ld_rdata_i[23:16];
            2'd2:    ld_byte = ld_rdata_i[15:8];
            default: ld_byte = ld_rdata_i[7:0];
        endcase
        ld_half = ld_off_i[1] ? ld_rdata_i[15:0] : ld_rdata_i[31:16];
        ld_sext = (ld_op_i == OP_LB) || (ld_op_i == OP_LH);
        case (op_size(ld_op_i))
            SZ_BYTE: ld_data_o = {{24{ld_sext & ld_byte[7]}}, ld_byte};
            SZ_HALF: ld_data_o = {{16{ld_sext & ld_half[15]}}, ld_half};
            default: ld_data_o = ld_rdata_i;
        endcase
    end
endmodule

// File: rtl/mips_lsu.sv
// Load/store unit: request FSM, registered memory/response outputs, LL/SC reservation.
//   state   | meaning
//   S_IDLE  | ready for a request
//   S_ISSUE | memory access pending, waiting for mem_ack
//   S_RESP  | one-cycle response pulse
module mips_lsu
    import mips_lsu_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int GRAN_LOG2 = 2
) (
    input logic       clk,
    input logic       rst,
    mips_lsu_if.slave bus
);
    localparam int TAG_W = ADDR_W - GRAN_LOG2;

    state_e            state_q, state_d;
    logic [3:0]        op_q, op_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              mem_req_q, mem_req_d;
    logic [3:0]        mem_we_q, mem_we_d;
    logic [31:0]       mem_wdata_q, mem_wdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic              rsp_we_q, rsp_we_d;
    logic              rsp_err_q, rsp_err_d;
    logic [31:0]       rsp_data_q, rsp_data_d;
    logic [4:0]        rsp_rd_q, rsp_rd_d;
    logic              resv_valid_q, resv_valid_d;
    logic [TAG_W-1:0]  resv_tag_q, resv_tag_d;

    logic [TAG_W-1:0]  req_tag, snoop_tag;
    logic              req_ok, sc_ok;
    logic [3:0]        st_strb;
    logic [31:0]       st_data, ld_data;

    assign req_tag   = bus.req_addr[ADDR_W-1:GRAN_LOG2];
    assign snoop_tag = bus.snoop_addr[ADDR_W-1:GRAN_LOG2];
    assign req_ok    = is_legal(bus.req_op) && is_aligned(bus.req_op, bus.req_addr[1:0]);
    // SC outcome is fixed at accept; a same-cycle snoop or clear already kills it.
    assign sc_ok     = resv_valid_q && (req_tag == resv_tag_q) && !bus.resv_clr
                       && !(bus.snoop_we && (snoop_tag == resv_tag_q));

    mips_lsu_lane u_lane (
        .st_op_i    (bus.req_op),
        .st_off_i   (bus.req_addr[1:0]),
        .st_data_i  (bus.req_wdata),
        .st_strb_o  (st_strb),
        .st_data_o  (st_data),
        .ld_op_i    (op_q),
        .ld_off_i   (addr_q[1:0]),
        .ld_rdata_i (bus.mem_rdata),
        .ld_data_o  (ld_data)
    );

    always_comb begin
        state_d      = state_q;
        op_d         = op_q;
        addr_d       = addr_q;
        mem_req_d    = 1'b0;
        mem_we_d     = 4'b0000;
        mem_wdata_d  = mem_wdata_q;
        rsp_valid_d  = 1'b0;
        rsp_we_d     = rsp_we_q;
        rsp_err_d    = rsp_err_q;
        rsp_data_d   = rsp_data_q;
        rsp_rd_d     = rsp_rd_q;
        resv_valid_d = resv_valid_q;
        resv_tag_d   = resv_tag_q;
        case (state_q)
            S_IDLE: begin
                if (bus.req_valid) begin
                    op_d     = bus.req_op;
                    addr_d   = bus.req_addr;
                    rsp_rd_d = bus.req_rd;
                    if ((is_store(bus.req_op) && (req_tag == resv_tag_q)) || (bus.req_op == OP_SC))
                        resv_valid_d = 1'b0;
                    if (!req_ok) begin
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b1;
                        rsp_we_d    = 1'b0;
                        rsp_data_d  = 32'd0;
                    end else if ((bus.req_op == OP_SC) && !sc_ok) begin
                        state_d     = S_RESP;
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b0;
                        rsp_we_d    = 1'b1;
                        rsp_data_d  = 32'd0;
                    end else begin
                        state_d     = S_ISSUE;
                        mem_req_d   = 1'b1;
                        mem_we_d    = (is_store(bus.req_op) || (bus.req_op == OP_SC)) ? st_strb : 4'b0000;
                        mem_wdata_d = st_data;
                    end
                end
            end
            S_ISSUE: begin
                if (bus.mem_ack) begin
                    state_d     = S_RESP;
                    rsp_valid_d = 1'b1;
                    rsp_err_d   = 1'b0;
                    rsp_we_d    = is_load(op_q) || (op_q == OP_SC);
                    rsp_data_d  = (op_q == OP_SC) ? 32'd1 : (is_store(op_q) ? 32'd0 : ld_data);
                    if (op_q == OP_LL) begin
                        resv_valid_d = 1'b1;
                        resv_tag_d   = addr_q[ADDR_W-1:GRAN_LOG2];
                    end
                end else begin
                    mem_req_d = 1'b1;
                    mem_we_d  = mem_we_q;
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        // Compared against the post-set tag so a clear always beats an LL set.
        if (bus.resv_clr || (bus.snoop_we && (snoop_tag == resv_tag_d)))
            resv_valid_d = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            op_q         <= 4'd0;
            addr_q       <= '0;
            mem_req_q    <= 1'b0;
            mem_we_q     <= 4'b0000;
            mem_wdata_q  <= 32'd0;
            rsp_valid_q  <= 1'b0;
            rsp_we_q     <= 1'b0;
            rsp_err_q    <= 1'b0;
            rsp_data_q   <= 32'd0;
            rsp_rd_q     <= 5'd0;
            resv_valid_q <= 1'b0;
            resv_tag_q   <= '0;
        end else begin
            state_q      <= state_d;
            op_q         <= op_d;
            addr_q       <= addr_d;
            mem_req_q    <= mem_req_d;
            mem_we_q     <= mem_we_d;
            mem_wdata_q  <= mem_wdata_d;
            rsp_valid_q  <= rsp_valid_d;
            rsp_we_q     <= rsp_we_d;
            rsp_err_q    <= rsp_err_d;
            rsp_data_q   <= rsp_data_d;
            rsp_rd_q     <= rsp_rd_d;
            resv_valid_q <= resv_valid_d;
            resv_tag_q   <= resv_tag_d;
        end
    end

    assign bus.req_ready = (state_q == S_IDLE);
    assign bus.mem_req   = mem_req_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = {addr_q[ADDR_W-1:2], 2'b00};
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_rd    = rsp_rd_q;
    assign bus.rsp_we    = rsp_we_q;
    assign bus.rsp_err   = rsp_err_q;

    logic unused_snoop_low;
    assign unused_snoop_low = ^bus.snoop_addr[GRAN_LOG2-1:0];
endmodule

// File: doc/mips_lsu.md
# mips_lsu

Parametrised load/store unit for the next-generation MIPS pipeline. It sits between the X stage and a variable-latency data memory, replacing the fixed single-cycle memory path. It adds halfword accesses, misalignment detection, and a real LL/SC reservation register with snoop invalidation. A request/acknowledge handshake stalls the pipeline on slow memory.

## Interface
Parameters:
- ADDR_W, 32, byte-address width.
- GRAN_LOG2, 2, log2 of reservation granule in bytes (2..ADDR_W-1).

Ports:
- Clock and reset: one clock; reset is synchronous and active-high.
  - clk  in  1  clock.
  - rst  in  1  reset.
- Pipeline request:
  - req_valid  in  1  request present.
  - req_ready  out  1  unit idle, request accepted this cycle.
  - req_op  in  4  LB=0, LBU=1, LH=2, LHU=3, LW=4, SB=5, SH=6, SW=7, LL=8, SC=9; others are illegal.
  - req_addr  in  ADDR_W  effective byte address.
  - req_wdata  in  32  store data, right-justified.
  - req_rd  in  5  destination register.
- Pipeline response:
  - rsp_valid  out  1  one-cycle response pulse.
  - rsp_data  out  32  formatted load data or SC flag.
  - rsp_rd  out  5  destination register.
  - rsp_we  out  1  register write required.
  - rsp_err  out  1  misaligned or illegal op.
- Memory:
  - mem_req  out  1  access pending.
  - mem_we  out  4  byte strobes; bit 3 = bits 31:24 (big-endian lanes); zero for reads.
  - mem_addr  out  ADDR_W  word-aligned address (low 2 bits zero).
  - mem_wdata  out  32  lane-replicated store data.
  - mem_ack  in  1  access complete; read data valid this cycle.
  - mem_rdata  in  32  read data.
- Reservation control:
  - snoop_we  in  1  another agent wrote.
  - snoop_addr  in  ADDR_W  address of that write.
  - resv_clr  in  1  clear reservation (exception/eret).

## Operation
- FSM states:
  - IDLE: req_ready=1.
  - ISSUE: mem_req=1; drive registered addr/strobes/data.
  - RESP: rsp_valid=1 for one cycle.
- Transitions:
  - IDLE→ISSUE on accept of a legal, aligned access that is not a failing SC.
  - IDLE→RESP on accept of a misaligned access, an illegal op, or a failing SC; no memory access in these cases.
  - ISSUE→RESP on mem_ack.
  - RESP→IDLE always.
- Alignment:
  - Halfword accesses require addr[0]=0.
  - Word, LL and SC accesses require addr[1:0]=0.
  - Violation: rsp_err=1, rsp_we=0, rsp_data=0.
- Store lanes:
  - SB: strobe 1000>>addr[1:0]; wdata = {4{wdata[7:0]}}.
  - SH: strobe 1100 if addr[1]=0, else 0011; wdata = {2{wdata[15:0]}}.
  - SW and successful SC: strobe 1111.
- Load formatting:
  - Byte and halfword lanes are selected big-endian by the registered addr.
  - LB and LH sign-extend; LBU and LHU zero-extend.
  - LW and LL return the word unchanged.
- Response flags:
  - Loads: rsp_we=1.
  - Stores: rsp_we=0.
  - SC: rsp_we=1; rsp_data=1 on success, 0 on failure.
- Reservation (resv_valid, resv_tag = addr[ADDR_W-1:GRAN_LOG2]):
  - LL sets it in the ISSUE cycle where mem_ack=1.
  - It is cleared by any accepted SC, by an accepted SB/SH/SW whose tag matches, by snoop_we with a matching tag, and by resv_clr.
- SC outcome is decided in its accept cycle. Success requires resv_valid & tag match, and no same-cycle matching snoop or resv_clr.
- Simultaneous events:
  - Set and clear in the same cycle (LL ack plus matching snoop, or LL ack plus resv_clr): clear wins.
  - Snoops while an SC is in ISSUE do not change its outcome.

## Timing
- Reset values: state IDLE; resv_valid=0.
- Reset output values: mem_req=0, mem_we=0, rsp_valid=0, rsp_err=0, rsp_we=0, rsp_data=0, req_ready=1.
- rst in any state takes effect at the next edge. A mem_ack arriving after reset while in IDLE is ignored.
- Accept occurs at cycle 0. mem_req rises at cycle 1 and is held with stable addr/we/wdata until mem_ack.
- If mem_ack arrives at cycle k≥1, rsp_valid is at k+1. With a zero-wait memory (ack at cycle 1), response is at cycle 2 and the next accept is at cycle 3.
- No-memory path: rsp_valid at cycle 1.
- All outputs are registered except req_ready, which decodes the state.
- rsp_* fields are valid only while rsp_valid=1 and hold their values otherwise.

## Structure
- Package mips_lsu_pkg holds:
  - op encodings and state enum;
  - is_load/is_store/size decode functions;
  - big-endian lane constants.
- Sub-module mips_lsu_lane (combinational): strobe and replicated-data generation; load extraction and extension.
- FSM and reservation stay in the top module.

## Test plan
- LB at 0x103 with mem_rdata=0x11_22_33_F0, ack at cycle 1 → rsp_data=0xFFFFFFF0 at cycle 2. LBU at the same address → 0x000000F0.
- SH at 0x202 with wdata=0xABCD1234 → mem_we=0011, mem_wdata=0x12341234, mem_addr=0x200. LH at 0x201 → rsp_err=1, no mem_req.
- LL at 0x300, then SC at 0x300 with wdata 7 → strobe 1111, rsp_data=1. A second SC → rsp_data=0, no mem_req.
- LL at 0x300, then snoop_we at 0x302 (GRAN_LOG2=2) → SC fails. Snoop at 0x304 instead → SC succeeds.
- LW with ack delayed 5 cycles → mem_req held stable for cycles 1–5, rsp_valid at cycle 6, req_ready=0 throughout.
- rst asserted in ISSUE → next cycle IDLE, mem_req=0, resv_valid=0; a late mem_ack produces no rsp_valid.
